uart_pkt_ctrl: RTL and testbench

UART_PKT_CTRL -- requirements
Module: uart_pkt_ctrl

---
 rtl/uart_pkt_ctrl_if.sv | 31 +++
 rtl/uart_pkt_ctrl.sv | 163 ++++++++++++++++
 tb/tb_uart_pkt_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkt_ctrl_if.sv
// Bundle of the UART byte streams and the ALU request/response signals.
// The slave modport is the controller's view; master is the environment's view.
interface uart_pkt_ctrl_if;
  logic [7:0]  rx_tdata_i;
  logic        rx_tvalid_i;
  logic        rx_tready_o;
  logic [7:0]  tx_tdata_o;
  logic        tx_tvalid_o;
  logic        tx_tready_i;
  logic        alu_op_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic        alu_valid_o;
  logic        alu_ready_i;
  logic [31:0] alu_res_i;
  logic        alu_res_valid_i;
  logic        busy_o;
  logic        err_o;

  modport slave (
    input  rx_tdata_i, rx_tvalid_i, tx_tready_i, alu_ready_i, alu_res_i, alu_res_valid_i,
    output rx_tready_o, tx_tdata_o, tx_tvalid_o, alu_op_o, alu_a_o, alu_b_o, alu_valid_o,
           busy_o, err_o
  );

  modport master (
    output rx_tdata_i, rx_tvalid_i, tx_tready_i, alu_ready_i, alu_res_i, alu_res_valid_i,
    input  rx_tready_o, tx_tdata_o, tx_tvalid_o, alu_op_o, alu_a_o, alu_b_o, alu_valid_o,
           busy_o, err_o
  );
endinterface

// File: rtl/uart_pkt_ctrl.sv
// Packet controller between a UART byte stream and an external add/mul ALU.
// Optional inter-byte timeout: define UART_PKT_CTRL_TIMEOUT_EN.
module uart_pkt_ctrl #(
  parameter int          DATA_WIDTH_P     = 8,
  parameter logic [15:0] TIMEOUT_CYCLES_P = 16'd4096
) (
  input logic            clk,
  input logic            rst_n,
  uart_pkt_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, HDR, ECHO, OPND, ALU_REQ, ALU_WAIT, TX_RES, DRAIN} state_t;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'h88;

  state_t      state;
  logic        run;
  logic [7:0]  opcode;
  logic [7:0]  len_lo;
  logic [15:0] cnt;
  logic [1:0]  bidx;
  logic        first;
  logic        op_mul;
  logic        err;
  logic [31:0] acc;
  logic [31:0] opnd;
  logic [31:0] txsh;

  logic        rx_fire;
  logic        tx_fire;
  logic [15:0] len;
  logic [15:0] rem;
  logic        len_ok;

  // run holds rx_tready low during reset and for the first edge after it
  assign bus.rx_tready_o = run && ((state inside {IDLE, HDR, OPND, DRAIN}) ||
                                   (state == ECHO && bus.tx_tready_i));
  assign bus.tx_tvalid_o = (state == ECHO && bus.rx_tvalid_i) || (state == TX_RES);
  assign bus.tx_tdata_o  = (state == ECHO) ? bus.rx_tdata_i : txsh[7:0];
  assign bus.alu_valid_o = (state == ALU_REQ);
  assign bus.alu_a_o     = acc;
  assign bus.alu_b_o     = opnd;
  assign bus.alu_op_o    = op_mul;
  assign bus.busy_o      = (state != IDLE);
  assign bus.err_o       = err;

  assign rx_fire = bus.rx_tvalid_i && bus.rx_tready_o;
  assign tx_fire = bus.tx_tvalid_o && bus.tx_tready_i;

  // len MSB is on the bus when the header completes
  assign len    = {bus.rx_tdata_i, len_lo};
  assign rem    = (len > 16'd4) ? len - 16'd4 : 16'd0;
  assign len_ok = (len[1:0] == 2'b00) && (len >= 16'd12);

`ifdef UART_PKT_CTRL_TIMEOUT_EN
  logic [15:0] idle_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES_P;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      run    <= 1'b0;
      opcode <= '0;
      len_lo <= '0;
      cnt    <= '0;
      bidx   <= '0;
      first  <= 1'b0;
      op_mul <= 1'b0;
      err    <= 1'b0;
      acc    <= '0;
      opnd   <= '0;
      txsh   <= '0;
`ifdef UART_PKT_CTRL_TIMEOUT_EN
      idle_cnt <= '0;
`endif
    end else begin
      run <= 1'b1;
      unique case (state)
        IDLE: if (rx_fire) begin
          opcode <= bus.rx_tdata_i;
          bidx   <= 2'd0;
          state  <= HDR;
        end
        HDR: if (rx_fire) begin
          bidx <= bidx + 2'd1;
          if (bidx == 2'd1) len_lo <= bus.rx_tdata_i;
          if (bidx == 2'd2) begin
            bidx   <= 2'd0;
            cnt    <= rem;
            first  <= 1'b1;
            op_mul <= (opcode == OP_MUL);
            if (opcode == OP_ECHO)
              state <= (rem == 16'd0) ? IDLE : ECHO;
            else if ((opcode == OP_ADD || opcode == OP_MUL) && len_ok)
              state <= OPND;
            else begin
              err   <= 1'b1;
              state <= (rem == 16'd0) ? IDLE : DRAIN;
            end
          end
        end
        ECHO, DRAIN: if (rx_fire) begin
          cnt <= cnt - 16'd1;
          if (cnt == 16'd1) state <= IDLE;
        end
        OPND: if (rx_fire) begin
          // little-endian: each new byte enters at the top and shifts down
          opnd <= {bus.rx_tdata_i, opnd[31:8]};
          cnt  <= cnt - 16'd1;
          bidx <= bidx + 2'd1;
          if (bidx == 2'd3) begin
            if (first) begin
              acc   <= {bus.rx_tdata_i, opnd[31:8]};
              first <= 1'b0;
            end else
              state <= ALU_REQ;
          end
        end
        ALU_REQ: if (bus.alu_ready_i) begin
          if (bus.alu_res_valid_i) begin
            acc <= bus.alu_res_i;
            if (cnt == 16'd0) begin
              txsh  <= bus.alu_res_i;
              state <= TX_RES;
            end else
              state <= OPND;
          end else
            state <= ALU_WAIT;
        end
        ALU_WAIT: if (bus.alu_res_valid_i) begin
          acc <= bus.alu_res_i;
          if (cnt == 16'd0) begin
            txsh  <= bus.alu_res_i;
            state <= TX_RES;
          end else
            state <= OPND;
        end
        TX_RES: if (tx_fire) begin
          txsh <= txsh >> DATA_WIDTH_P;
          bidx <= bidx + 2'd1;
          if (bidx == 2'd3) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef UART_PKT_CTRL_TIMEOUT_EN
      // overrides the case above when the link has gone quiet
      if ((state inside {HDR, OPND, ECHO, DRAIN}) && !rx_fire) begin
        if (idle_cnt == TIMEOUT_CYCLES_P - 16'd1) begin
          err      <= 1'b1;
          state    <= IDLE;
          idle_cnt <= '0;
        end else
          idle_cnt <= idle_cnt + 16'd1;
      end else
        idle_cnt <= '0;
`endif
    end
  end
endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Randomized bench for uart_pkt_ctrl: packet-level reference model predicts
// tx bytes and ALU requests; an ALU responder answers with random latency.
module tb_uart_pkt_ctrl;
  typedef logic [7:0]  b_q_t[$];
  typedef logic [31:0] w_q_t[$];
  typedef struct packed {logic op; logic [31:0] a; logic [31:0] b;} alu_req_t;

  logic clk = 1'b0;
  logic rst_n;
  int   nchk = 0;
  int   nerr = 0;
  int   gap_max = 0;
  int   tx_mode = 2;
  logic [7:0] txq[$];
  alu_req_t   alu_q[$];

  uart_pkt_ctrl_if bus();

  uart_pkt_ctrl #(.DATA_WIDTH_P(8), .TIMEOUT_CYCLES_P(16'd16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // tx sink: ready pattern by mode (0 random, 1 toggle, 2 always)
  initial begin
    bus.tx_tready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (tx_mode)
        0:       bus.tx_tready_i = 1'($urandom_range(0, 1));
        1:       bus.tx_tready_i = ~bus.tx_tready_i;
        default: bus.tx_tready_i = 1'b1;
      endcase
    end
  end

  // tx monitor: compare against predicted bytes, check hold while stalled
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  always @(negedge clk) begin
    if (!rst_n) prev_stall <= 1'b0;
    else begin
      if (prev_stall) chk("tx_hold", {bus.tx_tvalid_o, bus.tx_tdata_o}, {1'b1, prev_data});
      if (bus.tx_tvalid_o && bus.tx_tready_i) begin
        if (txq.size() == 0) chk("tx_extra", 1, 0);
        else chk("tx_byte", bus.tx_tdata_o, txq.pop_front());
      end
      prev_stall <= bus.tx_tvalid_o && !bus.tx_tready_i;
      prev_data  <= bus.tx_tdata_o;
    end
  end

  // ALU responder
  initial begin
    alu_req_t    e;
    logic [31:0] r;
    int          d;
    bit          same;
    bus.alu_ready_i = 1'b0; bus.alu_res_valid_i = 1'b0; bus.alu_res_i = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.alu_valid_o) begin
        if (alu_q.size() == 0) chk("alu_extra", 1, 0);
        else begin
          e = alu_q.pop_front();
          chk("alu_op", 32'(bus.alu_op_o), 32'(e.op));
          chk("alu_a", bus.alu_a_o, e.a);
          chk("alu_b", bus.alu_b_o, e.b);
        end
        r    = bus.alu_op_o ? bus.alu_a_o * bus.alu_b_o : bus.alu_a_o + bus.alu_b_o;
        same = 1'($urandom_range(0, 1));
        d    = $urandom_range(0, 2);
        repeat (d) begin
          @(negedge clk);
          chk("alu_hold", 32'(bus.alu_valid_o), 1);
        end
        @(posedge clk); #1;
        bus.alu_ready_i = 1'b1;
        if (same) begin bus.alu_res_valid_i = 1'b1; bus.alu_res_i = r; end
        @(posedge clk); #1;
        bus.alu_ready_i = 1'b0; bus.alu_res_valid_i = 1'b0;
        if (!same) begin
          repeat (d) begin @(posedge clk); #1; end
          bus.alu_res_valid_i = 1'b1; bus.alu_res_i = r;
          @(posedge clk); #1;
          bus.alu_res_valid_i = 1'b0;
        end
      end
    end
  end

  // all driver tasks start and end at posedge + #1
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_tvalid_i = 1'b1; bus.rx_tdata_i = b;
    @(negedge clk);
    while (!bus.rx_tready_o && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) chk("rx_stuck", 1, 0);
    @(posedge clk); #1;
    bus.rx_tvalid_i = 1'b0;
    repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
  endtask

  task automatic send_pkt(input b_q_t pk);
    foreach (pk[i]) send_byte(pk[i]);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((bus.busy_o || txq.size() != 0 || alu_q.size() != 0) && n < 3000);
    chk("idle_reached", 32'(n < 3000), 1);
    @(posedge clk); #1;
  endtask

  task automatic echo_pkt(input b_q_t pl);
    b_q_t pk;
    int   len = 4 + pl.size();
    pk.push_back(8'hEC); pk.push_back(8'h00);
    pk.push_back(len[7:0]); pk.push_back(len[15:8]);
    foreach (pl[i]) begin pk.push_back(pl[i]); txq.push_back(pl[i]); end
    send_pkt(pk);
    wait_idle();
  endtask

  task automatic arith(input bit mul, input w_q_t ops);
    b_q_t        pk;
    alu_req_t    e;
    logic [31:0] acc;
    int          len = 4 + 4 * ops.size();
    pk.push_back(mul ? 8'h88 : 8'hAD); pk.push_back(8'h00);
    pk.push_back(len[7:0]); pk.push_back(len[15:8]);
    foreach (ops[i]) for (int k = 0; k < 4; k++) pk.push_back(8'(ops[i] >> (8 * k)));
    acc = ops[0];
    for (int i = 1; i < ops.size(); i++) begin
      e.op = mul; e.a = acc; e.b = ops[i];
      alu_q.push_back(e);
      acc = mul ? acc * ops[i] : acc + ops[i];
    end
    for (int k = 0; k < 4; k++) txq.push_back(8'(acc >> (8 * k)));
    send_pkt(pk);
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdy"},   32'(bus.rx_tready_o), 0);
    chk({tag, "_txv"},   32'(bus.tx_tvalid_o), 0);
    chk({tag, "_txd"},   32'(bus.tx_tdata_o), 0);
    chk({tag, "_aluv"},  32'(bus.alu_valid_o), 0);
    chk({tag, "_alua"},  bus.alu_a_o, 0);
    chk({tag, "_alub"},  bus.alu_b_o, 0);
    chk({tag, "_busy"},  32'(bus.busy_o), 0);
    chk({tag, "_err"},   32'(bus.err_o), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2 check_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rdy_after_rst", 32'(bus.rx_tready_o), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    b_q_t pl;
    w_q_t ops;
    rst_n = 1'b0; bus.rx_tvalid_i = 1'b0; bus.rx_tdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rdy_after_por", 32'(bus.rx_tready_o), 1);
    @(posedge clk); #1;

    // directed echo / add / mul
    pl = '{8'h41, 8'h42, 8'h43};
    echo_pkt(pl);
    chk("echo_err", 32'(bus.err_o), 0);
    pl.delete();
    echo_pkt(pl);
    ops = '{32'd1, 32'd2};
    arith(1'b0, ops);
    tx_mode = 1;
    ops = '{32'd2, 32'd3, 32'd4};
    arith(1'b1, ops);
    tx_mode = 2;
    chk("arith_err", 32'(bus.err_o), 0);

    // randomized packets
    for (int p = 0; p < 40; p++) begin
      int kind = $urandom_range(0, 2);
      gap_max = $urandom_range(0, 2);
      tx_mode = $urandom_range(0, 2);
      if (kind == 0) begin
        pl.delete();
        repeat ($urandom_range(0, 8)) pl.push_back(8'($urandom));
        echo_pkt(pl);
      end else begin
        ops.delete();
        repeat ($urandom_range(2, 4))
          ops.push_back($urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 300)));
        arith(kind == 2, ops);
      end
    end
    chk("rand_err", 32'(bus.err_o), 0);
    tx_mode = 2; gap_max = 1;

    // bad opcode drains payload, sticky error, echo still works
    pl = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
    send_pkt(pl);
    wait_idle();
    chk("badop_err", 32'(bus.err_o), 1);
    pl = '{8'h5A};
    echo_pkt(pl);
    chk("badop_echo_err", 32'(bus.err_o), 1);
    // add with only one operand is a bad length
    pl = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt(pl);
    wait_idle();
    chk("badlen_err", 32'(bus.err_o), 1);
    do_reset();

    // reset mid-operand drops the packet
    pl = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00};
    send_pkt(pl);
    chk("mid_busy", 32'(bus.busy_o), 1);
    do_reset();
    ops = '{32'h0000_0100, 32'hFFFF_FF05};
    arith(1'b0, ops);
    chk("post_rst_err", 32'(bus.err_o), 0);

`ifdef UART_PKT_CTRL_TIMEOUT_EN
    pl = '{8'hAD, 8'h00, 8'h0C, 8'h00};
    gap_max = 0;
    send_pkt(pl);
    repeat (8) @(negedge clk);
    chk("to_wait_busy", 32'(bus.busy_o), 1);
    chk("to_wait_err", 32'(bus.err_o), 0);
    repeat (12) @(negedge clk);
    chk("to_err", 32'(bus.err_o), 1);
    chk("to_idle", 32'(bus.busy_o), 0);
    @(posedge clk); #1;
    do_reset();
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
